// File: rtl/segment_display_pkg.sv
// segment_display_pkg: shared digit patterns, FSM state and BCD types for the segment display decoder
//   SEG_0..SEG_9 : active-high {G,F,E,D,C,B,A} patterns of the legal digits
//   SEG_TABLE    : the same patterns indexed by digit value
//   state_t      : filter FSM state (ST_SETTLE, ST_HOLD)
//   bcd_t        : one BCD digit
//   bcd_inc      : two-digit BCD increment, wrapping 99 -> 00
package segment_display_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam logic [6:0] SEG_TABLE [10] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9
    };

    typedef logic [0:0] state_t;
    localparam state_t ST_SETTLE = 1'b0;
    localparam state_t ST_HOLD   = 1'b1;

    typedef logic [3:0] bcd_t;

    // Returns {tens, ones} of (tens*10 + ones + 1) mod 100.
    function automatic logic [7:0] bcd_inc(input bcd_t tens, input bcd_t ones);
        bcd_t next_tens;
        next_tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        return (ones == 4'd9) ? {next_tens, 4'd0} : {tens, ones + 4'd1};
    endfunction

endpackage

// File: rtl/seven_segment_to_bcd.sv
// seven_segment_to_bcd: combinational decode of one active-high 7-segment pattern to a BCD digit
//   i_Pattern : active-high segments {G,F,E,D,C,B,A}
//   o_Digit   : decoded digit 0-9 (0 when the pattern is not a digit)
//   o_Legal   : pattern is exactly one of the ten digit shapes
module seven_segment_to_bcd
    import segment_display_pkg::*;
(
    input  logic [6:0] i_Pattern,
    output bcd_t       o_Digit,
    output logic       o_Legal
);

    always_comb begin
        o_Digit = '0;
        o_Legal = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i_Pattern == SEG_TABLE[i]) begin
                o_Digit = 4'(i);
                o_Legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/segment_display_decoder.sv
// segment_display_decoder: filters two active-low 7-segment digits, decodes them and checks they count up by one
//   i_Clk, i_Rst_n          : clock, asynchronous active-low reset
//   i_Segment1, i_Segment2  : tens / ones segments {G,F,E,D,C,B,A}, active-low
//   o_Tens, o_Ones          : last accepted legal value
//   o_Valid                 : o_Tens/o_Ones hold a legal value
//   o_Update                : pulse, new legal value accepted
//   o_Seq_Error             : pulse, accepted value is not previous+1 mod 100
//   o_Illegal               : pulse, accepted pattern is not a digit
//   o_Error_Count           : saturating count of sequence and illegal events
module segment_display_decoder
    import segment_display_pkg::*;
#(
    parameter int unsigned c_STABLE_CYCLES = 16,
    parameter int unsigned c_ERR_WIDTH     = 8
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic [6:0]             i_Segment1,
    input  logic [6:0]             i_Segment2,
    output bcd_t                   o_Tens,
    output bcd_t                   o_Ones,
    output logic                   o_Valid,
    output logic                   o_Update,
    output logic                   o_Seq_Error,
    output logic                   o_Illegal,
    output logic [c_ERR_WIDTH-1:0] o_Error_Count
);

    localparam int unsigned CW = $clog2(c_STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(c_STABLE_CYCLES);

    logic [13:0]            sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [13:0]            last_pat_q, last_pat_d;
    logic                   last_vld_q, last_vld_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    state_t                 state_q, state_d;
    bcd_t                   tens_q, tens_d, ones_q, ones_d;
    logic                   valid_q, valid_d, update_q, update_d;
    logic                   seq_err_q, seq_err_d, illegal_q, illegal_d;
    logic [c_ERR_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic                   diff, eval, fresh, legal;
    logic                   tens_legal, ones_legal;
    bcd_t                   tens_dec, ones_dec, exp_tens, exp_ones;

    // prev_q is the stable candidate pattern once the filter count saturates
    seven_segment_to_bcd u_tens (.i_Pattern(prev_q[13:7]), .o_Digit(tens_dec), .o_Legal(tens_legal));
    seven_segment_to_bcd u_ones (.i_Pattern(prev_q[6:0]),  .o_Digit(ones_dec), .o_Legal(ones_legal));

    always_comb begin
        sync1_d = ~{i_Segment1, i_Segment2};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        diff    = sync2_q != prev_q;
        cnt_d   = diff ? '0 : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);
        // Evaluate once per settled pattern, and only if it is still stable this cycle
        eval    = (state_q == ST_SETTLE) && (cnt_q == CNT_MAX) && !diff;
        state_d = eval ? ST_HOLD : ((state_q == ST_HOLD && diff) ? ST_SETTLE : state_q);
        // A glitch that settles back to the last accepted pattern raises nothing
        fresh   = eval && !(last_vld_q && last_pat_q == prev_q);
        legal   = tens_legal && ones_legal;
        {exp_tens, exp_ones} = bcd_inc(tens_q, ones_q);
        update_d   = fresh && legal;
        illegal_d  = fresh && !legal;
        seq_err_d  = update_d && valid_q && (tens_dec != exp_tens || ones_dec != exp_ones);
        tens_d     = update_d ? tens_dec : tens_q;
        ones_d     = update_d ? ones_dec : ones_q;
        valid_d    = update_d ? 1'b1 : (illegal_d ? 1'b0 : valid_q);
        last_pat_d = fresh ? prev_q : last_pat_q;
        last_vld_d = last_vld_q | fresh;
        err_cnt_d  = ((seq_err_d || illegal_d) && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            last_pat_q <= '0;
            last_vld_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= ST_SETTLE;
            tens_q     <= '0;
            ones_q     <= '0;
            valid_q    <= 1'b0;
            update_q   <= 1'b0;
            seq_err_q  <= 1'b0;
            illegal_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            last_pat_q <= last_pat_d;
            last_vld_q <= last_vld_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            valid_q    <= valid_d;
            update_q   <= update_d;
            seq_err_q  <= seq_err_d;
            illegal_q  <= illegal_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_Tens        = tens_q;
    assign o_Ones        = ones_q;
    assign o_Valid       = valid_q;
    assign o_Update      = update_q;
    assign o_Seq_Error   = seq_err_q;
    assign o_Illegal     = illegal_q;
    assign o_Error_Count = err_cnt_q;

endmodule
